spi_slave_port: RTL
===================

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

Interface
REQ-001 SHALL have parameter FRAME_SIZE, default 8, meaning bits per SPI frame; legal range 4..16.
REQ-002 SHALL have parameter IDLE_DATA, default 8'hFF (FRAME_SIZE wide), meaning the word shifted out when no TX word is pending.
REQ-003 SHALL have port PCLK  in  1  meaning the single block clock; all logic runs on its rising edge.
REQ-004 SHALL have port PRESET  in  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port SPISSI  in  1  meaning the active-low slave select from the SPI master; asynchronous to PCLK.
REQ-006 SHALL have port SPICLKI  in  1  meaning the SPI serial clock from the master, Motorola mode 0 (CPOL=0, CPHA=0); asynchronous to PCLK.
REQ-007 SHALL have port SPISDI  in  1  meaning MOSI serial data, MSB first.
REQ-008 SHALL have port SPISDO  out  1  meaning MISO serial data, MSB first.
REQ-009 SHALL have port SPIOEN  out  1  meaning the MISO output enable, high while selected.
REQ-010 SHALL have port TX_DATA  in  FRAME_SIZE  meaning the next word to transmit.
REQ-011 SHALL have port TX_VALID  in  1  meaning TX_DATA is valid.
REQ-012 SHALL have port TX_READY  out  1  meaning the one-entry TX holding register is empty.
REQ-013 SHALL have port RX_DATA  out  FRAME_SIZE  meaning the last complete received word.
REQ-014 SHALL have port RX_VALID  out  1  meaning a one-PCLK pulse when RX_DATA updates.
REQ-015 SHALL have port TX_UNDERRUN  out  1  meaning a one-PCLK pulse when IDLE_DATA is loaded instead of a pending word.
REQ-016 SHALL have port FRAME_ABORT  out  1  meaning a one-PCLK pulse when SPISSI deasserts mid-frame.

Function
REQ-017 SHALL synchronize SPISSI, SPICLKI and SPISDI through 2 flops each, then register one more stage for edge detection (sclk_rise, sclk_fall, ss_fall, ss_rise); total input latency 3 PCLK.
REQ-018 SHALL require SPICLKI high and low phases of at least 4 PCLK each; faster clocks are out of spec and behaviour is undefined.
REQ-019 SHALL accept a TX word when TX_VALID && TX_READY; TX_READY falls the next cycle and rises again when the holding register is moved into the shift register.
REQ-020 SHALL implement the states IDLE (deselected), LOAD (one cycle, loads the TX shifter) and SHIFT.
REQ-021 SHALL move from IDLE to LOAD on ss_fall, and from LOAD to SHIFT unconditionally.
REQ-022 In LOAD, SHALL load the TX shifter from the holding register if full (emptying it), else from IDLE_DATA and pulse TX_UNDERRUN.
REQ-023 If a TX word is accepted in the same cycle as LOAD, SHALL still treat the holding register as empty: IDLE_DATA is sent and the new word stays held.
REQ-024 In SHIFT, on sclk_rise, SHALL shift the synchronized SPISDI into the RX shifter LSB and increment the bit counter.
REQ-025 When the counter reaches FRAME_SIZE, SHALL clear the counter, copy the RX shifter to RX_DATA, pulse RX_VALID in the following cycle, and set reload_pending.
REQ-026 On sclk_fall, SHALL go to LOAD if reload_pending is set (clearing it); otherwise SHALL shift the TX shifter left by one.
REQ-027 SHALL drive SPISDO = TX shifter MSB while SPIOEN is high, else 0; SPIOEN = registered inverse of synchronized SPISSI.
REQ-028 On ss_rise from any state other than IDLE, SHALL return to IDLE and clear the counter and reload_pending; if the counter is nonzero, SHALL pulse FRAME_ABORT and not assert RX_VALID.
REQ-029 The word consumed for an aborted frame SHALL be lost; the holding register SHALL be unaffected by an abort.
REQ-030 RX has no backpressure: RX_DATA SHALL be overwritten by each completed frame.

Reset
REQ-031 While PRESET is high at a PCLK edge, SHALL set state IDLE; counter 0; shifters 0; RX_DATA 0; RX_VALID, TX_UNDERRUN, FRAME_ABORT, SPISDO and SPIOEN 0; TX_READY 1; holding register empty.
REQ-032 Synchronizers SHALL reset to SS=1, SCLK=0, SDI=0 so that no spurious edge is detected after reset release.
REQ-033 Reset asserted mid-frame SHALL discard the frame without an RX_VALID or FRAME_ABORT pulse.

Verification
REQ-034 Load TX 8'hA5, select, master sends 8'h3C mode 0 -> MISO bits 1,0,1,0,0,1,0,1; RX_DATA=8'h3C with a single RX_VALID pulse; TX_READY returns to 1 at LOAD.
REQ-035 Select with no TX word loaded -> TX_UNDERRUN pulse, MISO carries 8'hFF, RX still captured.
REQ-036 Two back-to-back frames under one SS, TX words 8'h11 then 8'h22 supplied in time -> MISO 8'h11 then 8'h22, two RX_VALID pulses.
REQ-037 Deassert SPISSI after 5 SCLK rises -> FRAME_ABORT pulse, no RX_VALID, SPIOEN 0 within 4 PCLK, next frame decodes correctly.
REQ-038 TX_VALID presented in the LOAD cycle -> IDLE_DATA sent plus TX_UNDERRUN; the word is sent in the next frame.
REQ-039 Assert PRESET mid-frame -> all outputs at reset values, TX_READY=1, no pulses.

Source files
------------

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave port on a single PCLK domain: synchronized SPI inputs,
// a one-entry TX holding register, TX/RX shifters and frame control.
module spi_slave_port #(
  parameter int unsigned            FRAME_SIZE = 8,
  parameter logic [FRAME_SIZE-1:0]  IDLE_DATA  = FRAME_SIZE'(8'hFF)
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  SPISSI,
  input  logic                  SPICLKI,
  input  logic                  SPISDI,
  output logic                  SPISDO,
  output logic                  SPIOEN,
  input  logic [FRAME_SIZE-1:0] TX_DATA,
  input  logic                  TX_VALID,
  output logic                  TX_READY,
  output logic [FRAME_SIZE-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  TX_UNDERRUN,
  output logic                  FRAME_ABORT
);

  localparam int unsigned CNT_W = $clog2(FRAME_SIZE + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic ss_meta_q, ss_sync_q, ss_dly_q;
  logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
  logic sdi_meta_q, sdi_sync_q;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  reload_q, reload_d;
  logic [FRAME_SIZE-1:0] tx_sh_q, tx_sh_d;
  logic [FRAME_SIZE-1:0] rx_sh_q, rx_sh_d;
  logic [FRAME_SIZE-1:0] hold_q, hold_d;
  logic                  hold_empty_q, hold_empty_d;
  logic [FRAME_SIZE-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  abort_q, abort_d;
  logic                  spisdo_q, spisdo_d;
  logic                  spioen_q, spioen_d;

  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  assign sclk_rise = sclk_sync_q & ~sclk_dly_q;
  assign sclk_fall = ~sclk_sync_q & sclk_dly_q;
  assign ss_fall   = ~ss_sync_q & ss_dly_q;
  assign ss_rise   = ss_sync_q & ~ss_dly_q;

  // Synchronizers reset to the idle bus levels so release creates no edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ss_meta_q    <= 1'b1;
      ss_sync_q    <= 1'b1;
      ss_dly_q     <= 1'b1;
      sclk_meta_q  <= 1'b0;
      sclk_sync_q  <= 1'b0;
      sclk_dly_q   <= 1'b0;
      sdi_meta_q   <= 1'b0;
      sdi_sync_q   <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      reload_q     <= 1'b0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      hold_q       <= '0;
      hold_empty_q <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      underrun_q   <= 1'b0;
      abort_q      <= 1'b0;
      spisdo_q     <= 1'b0;
      spioen_q     <= 1'b0;
    end else begin
      ss_meta_q    <= SPISSI;
      ss_sync_q    <= ss_meta_q;
      ss_dly_q     <= ss_sync_q;
      sclk_meta_q  <= SPICLKI;
      sclk_sync_q  <= sclk_meta_q;
      sclk_dly_q   <= sclk_sync_q;
      sdi_meta_q   <= SPISDI;
      sdi_sync_q   <= sdi_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reload_q     <= reload_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      hold_q       <= hold_d;
      hold_empty_q <= hold_empty_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      underrun_q   <= underrun_d;
      abort_q      <= abort_d;
      spisdo_q     <= spisdo_d;
      spioen_q     <= spioen_d;
    end
  end

  // Frame control: holding-register handshake, load, shift and abort.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reload_d     = reload_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    hold_d       = hold_q;
    hold_empty_d = hold_empty_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    underrun_d   = 1'b0;
    abort_d      = 1'b0;

    if (TX_VALID && hold_empty_q) begin
      hold_d       = TX_DATA;
      hold_empty_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // A word accepted this very cycle is not yet visible here and stays held.
        if (!hold_empty_q) begin
          tx_sh_d      = hold_q;
          hold_empty_d = 1'b1;
        end else begin
          tx_sh_d    = IDLE_DATA;
          underrun_d = 1'b1;
        end
        if (ss_rise) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          reload_d = 1'b0;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          reload_d = 1'b0;
          abort_d  = (cnt_q != '0);
        end else if (sclk_rise) begin
          rx_sh_d = {rx_sh_q[FRAME_SIZE-2:0], sdi_sync_q};
          if (cnt_q == CNT_W'(FRAME_SIZE - 1)) begin
            cnt_d      = '0;
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
            reload_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            state_d  = ST_LOAD;
            reload_d = 1'b0;
          end else begin
            tx_sh_d = tx_sh_q << 1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    spioen_d = ~ss_sync_q;
    spisdo_d = spioen_d & tx_sh_d[FRAME_SIZE-1];
  end

  assign SPISDO      = spisdo_q;
  assign SPIOEN      = spioen_q;
  assign TX_READY    = hold_empty_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign TX_UNDERRUN = underrun_q;
  assign FRAME_ABORT = abort_q;

endmodule
